// File: rtl/tcdm_cfi_bank_responder.sv
// tcdm_cfi_bank_responder
//   Terminates one slave port of the interleaved L2 crossbar and drives a
//   single-ported SRAM bank. A request is granted only when its response can
//   be returned exactly one cycle later.
//
//   Optional feature macro: TCDM_RESP_RMW_EN
//     defined   -> partial-byte writes become read-modify-write sequences and
//                  mem_be_o is held all-ones (for macros without byte masks)
//     undefined -> every in-range write is one access with mem_be_o = be
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   tcdm_slave_*_i / *_o        TCDM CFI slave: req, add, wen (1=read),
//                               wdata, be, gnt, r_rdata, r_opc, r_valid
//   mem_req_o, mem_we_o         SRAM strobe, write(1)/read(0)
//   mem_addr_o, mem_wdata_o     SRAM word address, write data
//   mem_be_o                    SRAM byte mask
//   mem_gnt_i                   SRAM accepts the access this cycle
//   mem_rdata_i                 SRAM read data, valid the cycle after a read
//   dbg_state_o                 FSM state (0 IDLE, 1 RMW_RD, 2 RMW_WAIT)
//
// Handshake: a request is accepted in the cycle where req=1 and gnt=1. The
// requester holds add/wdata/be/wen stable while req=1 and gnt=0. r_valid is
// asserted exactly one cycle after every gnt, carrying r_rdata/r_opc.
module tcdm_cfi_bank_responder #(
  parameter int CFI_DATA_WIDTH = 40,
  parameter int NR_BANKS       = 4,
  parameter int NUM_WORDS      = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          tcdm_slave_req_i,
  input  logic [31:0]                   tcdm_slave_add_i,
  input  logic                          tcdm_slave_wen_i,
  input  logic [CFI_DATA_WIDTH-1:0]     tcdm_slave_wdata_i,
  input  logic [4:0]                    tcdm_slave_be_i,
  output logic                          tcdm_slave_gnt_o,
  output logic [CFI_DATA_WIDTH-1:0]     tcdm_slave_r_rdata_o,
  output logic                          tcdm_slave_r_opc_o,
  output logic                          tcdm_slave_r_valid_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [$clog2(NUM_WORDS)-1:0]  mem_addr_o,
  output logic [CFI_DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [4:0]                    mem_be_o,
  input  logic                          mem_gnt_i,
  input  logic [CFI_DATA_WIDTH-1:0]     mem_rdata_i,
  output logic [1:0]                    dbg_state_o
);

  localparam int BE_WIDTH = 5;
  localparam int AW       = $clog2(NUM_WORDS);
  localparam int BSEL     = $clog2(NR_BANKS);

  if (CFI_DATA_WIDTH != 8 * BE_WIDTH) begin : g_bad_data_width
    $error("CFI_DATA_WIDTH must equal 8*BE_WIDTH");
  end
  if (NR_BANKS < 1 || (NR_BANKS & (NR_BANKS - 1)) != 0) begin : g_bad_nr_banks
    $error("NR_BANKS must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RMW_RD   = 2'd1,
    RMW_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   r_valid_q, r_rd_q, r_err_q;
  logic   gnt;

  // Byte offset is the low 3 bits, the bank select sits above it.
  logic [31:0] word_idx;
  logic        in_range;
  assign word_idx = tcdm_slave_add_i >> (3 + BSEL);
  assign in_range = word_idx < 32'(NUM_WORDS);

`ifdef TCDM_RESP_RMW_EN
  logic [CFI_DATA_WIDTH-1:0] merge_q, merge_d, merged;

  always_comb begin
    merged = mem_rdata_i;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (tcdm_slave_be_i[k]) merged[8*k +: 8] = tcdm_slave_wdata_i[8*k +: 8];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt         = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
`ifdef TCDM_RESP_RMW_EN
    merge_d     = merge_q;
    mem_be_o    = '1;
`endif
    case (state_q)
      IDLE: begin
        if (tcdm_slave_req_i) begin
          if (!in_range) begin
            gnt = 1'b1;                 // error response, no SRAM access
          end else if (tcdm_slave_wen_i) begin
            mem_req_o  = 1'b1;
            mem_addr_o = word_idx[AW-1:0];
            gnt        = mem_gnt_i;
          end else if (tcdm_slave_be_i == '0) begin
            gnt = 1'b1;                 // nothing to write
`ifdef TCDM_RESP_RMW_EN
          end else if (tcdm_slave_be_i != '1) begin
            // Partial write: fetch the old word first, grant later.
            mem_req_o  = 1'b1;
            mem_addr_o = word_idx[AW-1:0];
            if (mem_gnt_i) state_d = RMW_RD;
`endif
          end else begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = word_idx[AW-1:0];
            mem_wdata_o = tcdm_slave_wdata_i;
`ifndef TCDM_RESP_RMW_EN
            mem_be_o    = tcdm_slave_be_i;
`endif
            gnt         = mem_gnt_i;
          end
        end
      end
`ifdef TCDM_RESP_RMW_EN
      RMW_RD: begin
        if (!tcdm_slave_req_i) begin
          state_d = IDLE;               // aborted: drop the write
        end else begin
          merge_d     = merged;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = word_idx[AW-1:0];
          mem_wdata_o = merged;
          if (mem_gnt_i) begin
            gnt     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RMW_WAIT;
          end
        end
      end
      RMW_WAIT: begin
        if (!tcdm_slave_req_i) begin
          state_d = IDLE;
        end else begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = word_idx[AW-1:0];
          mem_wdata_o = merge_q;
          if (mem_gnt_i) begin
            gnt     = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // While reset is held all outputs sit at their reset values even if a
    // request is still being presented.
    if (!rst_ni) begin
      gnt         = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      r_valid_q <= 1'b0;
      r_rd_q    <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_valid_q <= gnt;
      r_rd_q    <= gnt & tcdm_slave_wen_i & in_range;
      r_err_q   <= gnt & ~in_range;
    end
  end

`ifdef TCDM_RESP_RMW_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) merge_q <= '0;
    else         merge_q <= merge_d;
  end
`endif

  assign tcdm_slave_gnt_o     = gnt;
  assign tcdm_slave_r_valid_o = r_valid_q;
  assign tcdm_slave_r_opc_o   = r_err_q;
  // SRAM read data is forwarded straight through in the response cycle.
  assign tcdm_slave_r_rdata_o = (r_valid_q && r_rd_q) ? mem_rdata_i : '0;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_tcdm_cfi_bank_responder.sv
module tb_tcdm_cfi_bank_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wen, gnt, r_opc, r_valid;
  logic [31:0] add;
  logic [39:0] wdata, r_rdata;
  logic [4:0]  be;
  logic        mem_req, mem_we, mem_gnt;
  logic [11:0] mem_addr;
  logic [39:0] mem_wdata, mem_rdata;
  logic [4:0]  mem_be;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  tcdm_cfi_bank_responder #(
    .CFI_DATA_WIDTH(40), .NR_BANKS(4), .NUM_WORDS(4096)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tcdm_slave_req_i(req), .tcdm_slave_add_i(add), .tcdm_slave_wen_i(wen),
    .tcdm_slave_wdata_i(wdata), .tcdm_slave_be_i(be), .tcdm_slave_gnt_o(gnt),
    .tcdm_slave_r_rdata_o(r_rdata), .tcdm_slave_r_opc_o(r_opc),
    .tcdm_slave_r_valid_o(r_valid),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_rdata_i(mem_rdata), .dbg_state_o(dbg_state)
  );

  // SRAM model: byte-masked write, read data one cycle after the access.
  logic [39:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        for (int k = 0; k < 5; k++)
          if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [39:0] d, input logic [4:0] b);
    req = r; wen = w; add = a; wdata = d; be = b;
  endtask

  localparam logic [31:0] W5 = 32'h0000_00A0;  // word 5 with 4 banks
`ifdef TCDM_RESP_RMW_EN
  localparam logic [4:0] EXP_BE_FULL = 5'h1F;
`else
  localparam logic [4:0] EXP_BE_FULL = 5'h1F;
`endif

  int wr0;
  int resp_cnt;
  logic prev_gnt, exp_g;

  initial begin
    rst_n = 1'b0; mem_gnt = 1'b1; mem_rdata = '0;
    set_req(0, 0, 0, 0, 0);
    #3;
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_opc", r_opc, 0);
    chk("rst_r_rdata", r_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full write of word 5, then read back.
    set_req(1, 0, W5, 40'h12_3456_789A, 5'h1F); #1;
    chk("fw_gnt", gnt, 1);
    chk("fw_mem_req", mem_req, 1);
    chk("fw_mem_we", mem_we, 1);
    chk("fw_mem_addr", mem_addr, 5);
    chk("fw_mem_wdata", mem_wdata, 40'h12_3456_789A);
    chk("fw_mem_be", mem_be, EXP_BE_FULL);
    tick();
    set_req(1, 1, W5, 0, 0); #1;
    chk("fw_r_valid", r_valid, 1);
    chk("fw_r_opc", r_opc, 0);
    chk("fw_r_rdata", r_rdata, 0);
    chk("rd_gnt", gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    tick();
    req = 0; #1;
    chk("rd_r_valid", r_valid, 1);
    chk("rd_r_rdata", r_rdata, 40'h12_3456_789A);
    chk("rd_r_opc", r_opc, 0);
    tick();
    chk("idle_r_valid", r_valid, 0);

    // Partial write, byte 0 only.
    set_req(1, 0, W5, 40'hFF_FFFF_FFFF, 5'h01); #1;
`ifdef TCDM_RESP_RMW_EN
    chk("pw_gnt0", gnt, 0);
    chk("pw_rd_req", mem_req, 1);
    chk("pw_rd_we", mem_we, 0);
    tick();
    chk("pw_state_rd", dbg_state, 1);
    chk("pw_gnt1", gnt, 1);
    chk("pw_wr_we", mem_we, 1);
    chk("pw_wr_data", mem_wdata, 40'h12_3456_78FF);
    chk("pw_wr_be", mem_be, 5'h1F);
    chk("pw_r_valid1", r_valid, 0);
`else
    chk("pw_gnt0", gnt, 1);
    chk("pw_wr_we", mem_we, 1);
    chk("pw_wr_be", mem_be, 5'h01);
    chk("pw_wr_data", mem_wdata, 40'hFF_FFFF_FFFF);
`endif
    tick();
    req = 0; #1;
    chk("pw_r_valid", r_valid, 1);
    chk("pw_state_idle", dbg_state, 0);
    tick();
    set_req(1, 1, W5, 0, 0); #1;
    tick();
    req = 0; #1;
    chk("pw_readback", r_rdata, 40'h12_3456_78FF);
    tick();

`ifdef TCDM_RESP_RMW_EN
    // Partial write with the bank busy for 3 cycles after the RMW read.
    set_req(1, 0, W5, 40'h12_3456_789A, 5'h1F); #1;
    tick();
    set_req(1, 0, W5, 40'hFF_FFFF_FFFF, 5'h01); #1;
    chk("bz_gnt0", gnt, 0);
    tick();
    wr0 = wr_cnt;
    mem_gnt = 0; #1;
    chk("bz_state_rd", dbg_state, 1);
    chk("bz_gnt_rd", gnt, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_gnt = 1;
      #1;
      chk("bz_state_wait", dbg_state, 2);
      chk("bz_r_valid", r_valid, 0);
      chk("bz_gnt", gnt, (i == 2) ? 1 : 0);
      if (i == 2) chk("bz_wdata", mem_wdata, 40'h12_3456_78FF);
      tick();
    end
    req = 0; #1;
    chk("bz_r_valid_resp", r_valid, 1);
    chk("bz_one_write", wr_cnt - wr0, 1);
    tick();
`endif

    // Out-of-range read and the last in-range word.
    set_req(1, 1, 32'h0002_0000, 0, 0); #1;
    chk("oor_mem_req", mem_req, 0);
    chk("oor_gnt", gnt, 1);
    tick();
    set_req(1, 1, 32'h0001_FFE0, 0, 0); #1;
    chk("oor_r_valid", r_valid, 1);
    chk("oor_r_opc", r_opc, 1);
    chk("oor_r_rdata", r_rdata, 0);
    chk("last_mem_req", mem_req, 1);
    chk("last_mem_addr", mem_addr, 12'hFFF);
    tick();
    req = 0; #1;
    chk("last_r_opc", r_opc, 0);
    tick();

    // Write with no byte enabled.
    set_req(1, 0, W5, 40'h55_5555_5555, 5'h00); #1;
    chk("be0_mem_req", mem_req, 0);
    chk("be0_gnt", gnt, 1);
    tick();
    req = 0; #1;
    chk("be0_r_valid", r_valid, 1);
    chk("be0_r_opc", r_opc, 0);
    tick();

    // 8 reads against a bank that is busy every other cycle.
    set_req(1, 1, W5, 0, 0);
    prev_gnt = 0; resp_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      exp_g = (c % 2 == 0);
      mem_gnt = exp_g; #1;
      chk("b2b_gnt", gnt, exp_g);
      chk("b2b_r_valid", r_valid, prev_gnt);
      if (prev_gnt) chk("b2b_rdata", r_rdata, 40'h12_3456_78FF);
      if (r_valid) resp_cnt++;
      prev_gnt = exp_g;
      tick();
    end
    req = 0; mem_gnt = 1; #1;
    chk("b2b_r_valid_last", r_valid, prev_gnt);
    if (r_valid) resp_cnt++;
    tick();
    chk("b2b_r_valid_end", r_valid, 0);
    chk("b2b_resp_cnt", resp_cnt, 8);

    // Reset asserted one cycle into a partial write.
    wr0 = wr_cnt;
    set_req(1, 0, W5, 40'hAA_AAAA_AAAA, 5'h01); #1;
    tick();
`ifdef TCDM_RESP_RMW_EN
    chk("rr_state_rd", dbg_state, 1);
`endif
    rst_n = 0; #1;
    chk("rr_state", dbg_state, 0);
    chk("rr_mem_req", mem_req, 0);
    chk("rr_mem_we", mem_we, 0);
    chk("rr_mem_be", mem_be, 0);
    chk("rr_mem_wdata", mem_wdata, 0);
    chk("rr_gnt", gnt, 0);
    chk("rr_r_valid", r_valid, 0);
    chk("rr_r_rdata", r_rdata, 0);
    tick();
    req = 0; rst_n = 1;
    tick();
    chk("rr_r_valid_after", r_valid, 0);
`ifdef TCDM_RESP_RMW_EN
    chk("rr_no_write", wr_cnt - wr0, 0);
`else
    chk("rr_writes", wr_cnt - wr0, 1);
`endif
    set_req(1, 1, W5, 0, 0); #1;
    tick();
    req = 0; #1;
`ifdef TCDM_RESP_RMW_EN
    chk("rr_readback", r_rdata, 40'h12_3456_78FF);
`else
    chk("rr_readback", r_rdata, 40'h12_3456_78AA);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_cfi_bank_responder.md
# tcdm_cfi_bank_responder

Terminates one slave port of the interleaved L2 crossbar and drives a single-ported SRAM bank. It grants TCDM requests only when it can answer exactly one cycle later, matching the crossbar's fixed response latency of 1 with write responses enabled. It returns read data plus the `r_opc` error flag. Optionally, it turns partial-byte writes into read-modify-write sequences for SRAM macros without byte masking.

## Interface
Parameters:
- `CFI_DATA_WIDTH`, 40: TCDM data width. Must equal 8*BE_WIDTH; elaboration error otherwise.
- `NR_BANKS`, 4: interleave factor of the feeding crossbar. Power of two; elaboration error otherwise.
- `NUM_WORDS`, 4096: bank depth in words.
- `BE_WIDTH`, 5: localparam, fixed. One bit per byte lane `[8k+7:8k]`.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `tcdm_slave`  XBAR_TCDM_BUS_CFI.Slave  —  request from the crossbar. Signals used: `req`, `add`[32], `wen` (1=read, 0=write), `wdata`[CFI_DATA_WIDTH], `be`[5], `gnt`, `r_rdata`, `r_opc`, `r_valid`.
- `mem_req_o`  out  1  SRAM access strobe
- `mem_we_o`  out  1  SRAM write (1) / read (0)
- `mem_addr_o`  out  $clog2(NUM_WORDS)  word address
- `mem_wdata_o`  out  CFI_DATA_WIDTH  write data
- `mem_be_o`  out  5  byte mask. Driven all-ones when TCDM_RESP_RMW_EN is defined.
- `mem_gnt_i`  in  1  SRAM accepts access this cycle. Low means bank busy.
- `mem_rdata_i`  in  CFI_DATA_WIDTH  read data, valid the cycle after an accepted read

## Operation
- Word index is `add >> (3 + $clog2(NR_BANKS))`. Low 3 bits are the byte offset, next bits are the bank select.
- Out of range means index ≥ NUM_WORDS. Such a request is granted without any SRAM access; the response has `r_opc=1` and `r_rdata=0`.
- In-range read or full write (be=5'h1F):
  - `mem_req_o=req`.
  - `gnt=req & mem_gnt_i`, combinational.
- Write with be=0: granted immediately, no SRAM access, `r_opc=0`.
- FSM states: IDLE, RMW_RD, RMW_WAIT. Only IDLE is reachable without the macro.
  - IDLE → RMW_RD: partial write (be≠0, be≠1F, in range) with `mem_gnt_i=1`. An SRAM read is issued, `gnt=0`.
  - RMW_RD:
    - Merge `mem_rdata_i` with `wdata` under `be`, into `merge_q`.
    - If `mem_gnt_i`: write the merged word, `gnt=1`, go to IDLE.
    - Else: go to RMW_WAIT.
  - RMW_WAIT: write `merge_q` when `mem_gnt_i=1`, `gnt=1`, go to IDLE.
  - `req` low in RMW_RD/RMW_WAIT: abort to IDLE. No write, no response.
- Response register: `r_valid_q <= gnt`. It records read/write and error for the granted request.
- `r_rdata`:
  - Read, no error: `mem_rdata_i`, combinational passthrough in the `r_valid` cycle.
  - Otherwise: 0.
- `r_opc`: registered error flag, 0 for all in-range accesses.

## Timing
- Reset values: `r_valid=0`, `r_opc=0`, `r_rdata=0`, `mem_req_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`, `mem_be_o=0`, FSM=IDLE, `merge_q=0`.
- Latency: `r_valid` rises exactly 1 cycle after `gnt` for every granted request, with no exceptions. Back-to-back grants give back-to-back responses.
- Grant latency:
  - Read, full write, error, be=0: 0 cycles while `mem_gnt_i=1`.
  - Partial write under RMW: 1 cycle, plus any busy cycles in RMW_WAIT.
- The requester holds `add`/`wdata`/`be`/`wen` stable while `req=1` and `gnt=0`.
- Reset asserted mid-RMW: FSM goes to IDLE, pending write is dropped, `r_valid` forced 0 asynchronously.

## Configuration
- `TCDM_RESP_RMW_EN` defined:
  - Partial writes use the RMW FSM.
  - `mem_be_o` is tied to 5'h1F.
- Undefined:
  - No FSM states beyond IDLE.
  - Every in-range write is a single access with `mem_be_o=be`.
  - `merge_q` is absent.

## Test plan
- Write 0x12_3456_789A to word 5 (be=1F), then read it back. Expected: gnt same cycle, r_valid +1, read returns 0x12_3456_789A, r_opc=0.
- With the macro defined, word 5 holds 0x12_3456_789A; write wdata=0xFF_FFFF_FFFF, be=5'h01. Expected:
  - gnt at cycle+1.
  - SRAM sees a read, then a write of 0x12_3456_78FF.
  - r_valid at cycle+2.
- Same partial write with `mem_gnt_i` forced low for 3 cycles after the RMW read. Expected: RMW_WAIT held 3 cycles, then write 0x12_3456_78FF, gnt, r_valid one cycle later.
- Read with word index NUM_WORDS. Expected: no mem_req_o, gnt immediate, r_valid +1 with r_opc=1, r_rdata=0.
- 8 back-to-back reads with `mem_gnt_i` toggling 1,0,1,0… Expected: gnt only on high cycles, r_valid exactly one cycle after each gnt, 8 responses total.
- Assert rst_ni during RMW_RD. Expected: outputs at reset values immediately, no SRAM write, no r_valid after release.
